// File: rtl/sram_arb2_pkg.sv
// sram_arb2_pkg: shared definitions for the two-requester SRAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   ID_M0 / ID_M1           : requester IDs (m0 = instruction fetch, m1 = load/store)
//   rr_pick                 : round-robin pick between two requesters
package sram_arb2_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  // When both request, the one that was not granted last wins;
  // a lone requester always wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    if (req1)         return ID_M1;
    return ID_M0;
  endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// sram_arb_idfifo: synchronous 1-bit FIFO holding the requester ID of each
// outstanding command.
//   clk, rst      : clock, asynchronous active-low reset
//   push, din     : write enable / ID written (honoured when not full, or full with pop)
//   pop           : read enable (ignored when empty)
//   dout          : ID at the head
//   full, empty   : occupancy flags
//   count         : number of entries held
module sram_arb_idfifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       din,
  input  logic                       pop,
  output logic                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push & (~full | do_pop);

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arb2.sv
// sram_arb2: two-requester round-robin arbiter in front of the single-port
// SRAM controller cmd/rsp interface. Responses return in order and are routed
// to the issuing requester via an outstanding-ID FIFO.
//   clk, rst          : clock, asynchronous active-low reset
//   m0_* / m1_*       : requester cmd (vld/rdy/addr/read/wdata/wmask) and
//                       rsp (vld/rdy/err/rdata) channels; m0 = ifetch, m1 = lsu
//   s_cmd_*           : muxed command to the SRAM controller
//   s_rsp_*           : response from the SRAM controller
module sram_arb2
  import sram_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned OUTS_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_cmd_vld,
  output logic                m0_cmd_rdy,
  input  logic [ADDR_W-1:0]   m0_cmd_addr,
  input  logic                m0_cmd_read,
  input  logic [DATA_W-1:0]   m0_cmd_wdata,
  input  logic [DATA_W/8-1:0] m0_cmd_wmask,
  output logic                m0_rsp_vld,
  input  logic                m0_rsp_rdy,
  output logic                m0_rsp_err,
  output logic [DATA_W-1:0]   m0_rsp_rdata,

  input  logic                m1_cmd_vld,
  output logic                m1_cmd_rdy,
  input  logic [ADDR_W-1:0]   m1_cmd_addr,
  input  logic                m1_cmd_read,
  input  logic [DATA_W-1:0]   m1_cmd_wdata,
  input  logic [DATA_W/8-1:0] m1_cmd_wmask,
  output logic                m1_rsp_vld,
  input  logic                m1_rsp_rdy,
  output logic                m1_rsp_err,
  output logic [DATA_W-1:0]   m1_rsp_rdata,

  output logic                s_cmd_vld,
  input  logic                s_cmd_rdy,
  output logic [ADDR_W-1:0]   s_cmd_addr,
  output logic                s_cmd_read,
  output logic [DATA_W-1:0]   s_cmd_wdata,
  output logic [DATA_W/8-1:0] s_cmd_wmask,
  input  logic                s_rsp_vld,
  output logic                s_rsp_rdy,
  input  logic                s_rsp_err,
  input  logic [DATA_W-1:0]   s_rsp_rdata
);

  localparam int unsigned CNT_W = $clog2(OUTS_DEPTH + 1);
  localparam logic [CNT_W-1:0] MAX_OUTS = CNT_W'(OUTS_DEPTH);

  logic             last_gnt;
  logic             lock;
  logic             lock_id;
  logic             gnt;
  logic             full_n;
  logic             push;
  logic             pop;
  logic             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // ---------------- command side ----------------
  // While the controller stalls the grant is frozen so the payload it sees
  // stays stable until the handshake.
  always_comb begin
    gnt = lock ? lock_id : rr_pick(m0_cmd_vld, m1_cmd_vld, last_gnt);
  end

  assign full_n     = (fifo_count < MAX_OUTS) | pop;
  assign s_cmd_vld  = (m0_cmd_vld | m1_cmd_vld) & full_n;
  assign push       = s_cmd_vld & s_cmd_rdy;
  assign m0_cmd_rdy = (gnt == ID_M0) & s_cmd_rdy & full_n;
  assign m1_cmd_rdy = (gnt == ID_M1) & s_cmd_rdy & full_n;

  always_comb begin
    s_cmd_addr  = m0_cmd_addr;
    s_cmd_read  = m0_cmd_read;
    s_cmd_wdata = m0_cmd_wdata;
    s_cmd_wmask = m0_cmd_wmask;
    if (gnt == ID_M1) begin
      s_cmd_addr  = m1_cmd_addr;
      s_cmd_read  = m1_cmd_read;
      s_cmd_wdata = m1_cmd_wdata;
      s_cmd_wmask = m1_cmd_wmask;
    end
  end

  // last_gnt resets to m1 so m0 holds first priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt <= ID_M1;
      lock     <= 1'b0;
      lock_id  <= ID_M0;
    end else if (push) begin
      last_gnt <= gnt;
      lock     <= 1'b0;
    end else if (s_cmd_vld) begin
      lock     <= 1'b1;
      lock_id  <= gnt;
    end
  end

  // ---------------- response side ----------------
  // With no command outstanding, a response from the controller is spurious:
  // it is neither forwarded nor consumed.
  always_comb begin
    m0_rsp_vld = 1'b0;
    m1_rsp_vld = 1'b0;
    s_rsp_rdy  = 1'b0;
    if (!fifo_empty) begin
      if (head == ID_M1) begin
        m1_rsp_vld = s_rsp_vld;
        s_rsp_rdy  = m1_rsp_rdy;
      end else begin
        m0_rsp_vld = s_rsp_vld;
        s_rsp_rdy  = m0_rsp_rdy;
      end
    end
  end

  assign pop = s_rsp_vld & s_rsp_rdy;

  assign m0_rsp_rdata = s_rsp_rdata;
  assign m1_rsp_rdata = s_rsp_rdata;
  assign m0_rsp_err   = s_rsp_err;
  assign m1_rsp_err   = s_rsp_err;

  sram_arb_idfifo #(
    .DEPTH (OUTS_DEPTH)
  ) u_idfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (gnt),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A command is only ever accepted into a full FIFO when a pop frees a slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    fifo_full |-> !(push && !pop));

endmodule
